data_mem_resp: RTL and testbench

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/data_mem_resp_if.sv | 21 ++
 rtl/data_mem_resp.sv | 140 ++++++++++++++
 tb/tb_data_mem_resp.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/data_mem_resp_if.sv
// Data-memory bus between the load/store unit (master) and data_mem_resp (slave).
// Signals:
//   cs        chip select, active-high
//   we        1 = store, 0 = load
//   mask      byte enables, bit i -> bits [8i+7:8i]
//   addr      byte address, addr[1:0] ignored
//   wdata     lane-aligned store data
//   readData  combinational load data (full word)
//   err       combinational unmapped-access flag
interface data_mem_resp_if;
    logic        cs;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] readData;
    logic        err;

    modport master (output cs, we, mask, addr, wdata, input readData, err);
    modport slave  (input cs, we, mask, addr, wdata, output readData, err);
endinterface

// File: rtl/data_mem_resp.sv
// Data memory with a one-entry posted write buffer and an optional timer block.
// Ports:
//   clk    single clock, posedge
//   rst    asynchronous reset, active-low
//   bus    data_mem_resp_if.slave (cs/we/mask/addr/wdata in, readData/err out)
//   irq    registered, sticky timer interrupt (0 when the timer is not built)
// Optional feature: define DATA_MEM_RESP_TIMER_EN to build the timer registers
// at TIMER_BASE (+0 mtime RO, +4 mtimecmp RW, +8 status bit0=irq W1C).
module data_mem_resp #(
    parameter int          DEPTH      = 1024,
    parameter logic [31:0] TIMER_BASE = 32'hFFFF_0000
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_resp_if.slave bus,
    output logic           irq
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH) << 2;

    logic [31:0]   ram [DEPTH];

    logic          buf_vld;
    logic [AW-1:0] buf_idx;
    logic [3:0]    buf_mask;
    logic [31:0]   buf_data;

    logic [AW-1:0] widx;
    logic          ram_hit;
    logic          tmr_hit;
    logic          st_ok;
    logic          fwd;
    logic [31:0]   ram_word;
    logic [31:0]   merged;

    assign widx    = bus.addr[AW+1:2];
    assign ram_hit = ({1'b0, bus.addr} < RAM_BYTES);
    // Zero-mask stores are dropped entirely so they never occupy the buffer.
    assign st_ok   = bus.cs && bus.we && ram_hit && (bus.mask != 4'b0000);

    // Write buffer: refill and drain share one edge, so valid simply follows
    // whether a new store is accepted this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_vld  <= 1'b0;
            buf_idx  <= '0;
            buf_mask <= '0;
            buf_data <= '0;
        end else begin
            buf_vld <= st_ok;
            if (st_ok) begin
                buf_idx  <= widx;
                buf_mask <= bus.mask;
                buf_data <= bus.wdata;
            end
        end
    end

    // RAM is never reset; a pending entry discarded by reset has buf_vld
    // already cleared asynchronously, so it cannot drain.
    always_ff @(posedge clk) begin
        if (buf_vld) begin
            for (int i = 0; i < 4; i++) begin
                if (buf_mask[i]) ram[buf_idx][8*i +: 8] <= buf_data[8*i +: 8];
            end
        end
    end

    // Load path: RAM word with enabled buffered lanes forwarded on an index hit.
    always_comb begin
        ram_word = ram[widx];
        fwd      = buf_vld && (buf_idx == widx);
        merged   = ram_word;
        for (int i = 0; i < 4; i++) begin
            if (fwd && buf_mask[i]) merged[8*i +: 8] = buf_data[8*i +: 8];
        end
    end

`ifdef DATA_MEM_RESP_TIMER_EN
    logic [31:0] mtime;
    logic [31:0] mtimecmp;
    logic        irq_q;
    logic [29:0] toff;
    logic        tmr_wr;

    // Word offset from the timer base; wraps for addresses below the base,
    // so an unsigned range check covers both sides.
    assign toff    = bus.addr[31:2] - TIMER_BASE[31:2];
    assign tmr_hit = (toff < 30'd3);
    assign tmr_wr  = bus.cs && bus.we && tmr_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime    <= '0;
            mtimecmp <= 32'hFFFF_FFFF;
            irq_q    <= 1'b0;
        end else begin
            mtime <= mtime + 32'd1;
            if (tmr_wr && toff == 30'd1) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.mask[i]) mtimecmp[8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
            // Match wins over a same-edge status clear.
            if (mtime == mtimecmp)
                irq_q <= 1'b1;
            else if (tmr_wr && toff == 30'd2 && bus.mask[0] && bus.wdata[0])
                irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;

    always_comb begin
        bus.readData = '0;
        if (bus.cs && !bus.we) begin
            if (ram_hit) begin
                bus.readData = merged;
            end else if (tmr_hit) begin
                case (toff[1:0])
                    2'd0:    bus.readData = mtime;
                    2'd1:    bus.readData = mtimecmp;
                    default: bus.readData = {31'd0, irq_q};
                endcase
            end
        end
    end
`else
    assign tmr_hit = 1'b0;
    assign irq     = 1'b0;

    always_comb begin
        bus.readData = '0;
        if (bus.cs && !bus.we && ram_hit) bus.readData = merged;
    end
`endif

    assign bus.err = bus.cs && !ram_hit && !tmr_hit;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed self-checking bench for data_mem_resp (default DEPTH/TIMER_BASE).
// Timer checks follow whichever way DATA_MEM_RESP_TIMER_EN is set.
module tb_data_mem_resp;
    localparam logic [31:0] TB = 32'hFFFF_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic irq;
    int   tests = 0;
    int   fails = 0;

    data_mem_resp_if bus ();

    data_mem_resp #(.DEPTH(1024), .TIMER_BASE(TB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .irq (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic c, input logic w, input logic [3:0] m,
                       input logic [31:0] a, input logic [31:0] d);
        bus.cs    = c;
        bus.we    = w;
        bus.mask  = m;
        bus.addr  = a;
        bus.wdata = d;
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        idle();
        // Reset state with cs=0
        #2;
        chk("rst_rdata", bus.readData, 32'h0);
        chk("rst_err", {31'd0, bus.err}, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        step();
        rst = 1'b1;

        // Store then forwarded load, then load from RAM two cycles later
        step();
        drv(1, 1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        chk("store_rdata0", bus.readData, 32'h0);
        chk("store_err0", {31'd0, bus.err}, 32'h0);
        step();
        drv(1, 0, 4'hF, 32'h10, 32'h0);
        chk("fwd_full", bus.readData, 32'hDEAD_BEEF);
        step();
        idle();
        chk("cs0_rdata", bus.readData, 32'h0);
        step();
        drv(1, 0, 4'hF, 32'h10, 32'h0);
        chk("ram_full", bus.readData, 32'hDEAD_BEEF);

        // Partial-lane forwarding merge
        step();
        drv(1, 1, 4'hF, 32'h20, 32'h1122_3344);
        step();
        idle();
        step();
        drv(1, 1, 4'b0001, 32'h20, 32'h0000_00AA);
        step();
        drv(1, 0, 4'hF, 32'h20, 32'h0);
        chk("fwd_merge", bus.readData, 32'h1122_33AA);
        step();
        drv(1, 0, 4'hF, 32'h22, 32'h0);
        chk("ram_merge", bus.readData, 32'h1122_33AA);

        // Back-to-back stores: drain and refill on one edge
        step();
        drv(1, 1, 4'hF, 32'h0, 32'h1);
        step();
        drv(1, 1, 4'hF, 32'h4, 32'h2);
        step();
        drv(1, 0, 4'hF, 32'h0, 32'h0);
        chk("b2b_ld0", bus.readData, 32'h1);
        drv(1, 0, 4'hF, 32'h4, 32'h0);
        chk("b2b_ld4", bus.readData, 32'h2);
        step();
        idle();
        step();
        drv(1, 0, 4'hF, 32'h4, 32'h0);
        chk("b2b_ld4_ram", bus.readData, 32'h2);

        // Zero-mask store is ignored
        step();
        drv(1, 1, 4'h0, 32'h10, 32'h9999_9999);
        step();
        drv(1, 0, 4'hF, 32'h10, 32'h0);
        chk("mask0_fwd", bus.readData, 32'hDEAD_BEEF);
        step();
        idle();
        step();
        drv(1, 0, 4'hF, 32'h10, 32'h0);
        chk("mask0_ram", bus.readData, 32'hDEAD_BEEF);

        // Unmapped load and store
        drv(1, 0, 4'hF, 32'h8000_0000, 32'h0);
        chk("unmap_ld_err", {31'd0, bus.err}, 32'h1);
        chk("unmap_ld_rdata", bus.readData, 32'h0);
        step();
        drv(1, 1, 4'hF, 32'h8000_0010, 32'h0000_0077);
        chk("unmap_st_err", {31'd0, bus.err}, 32'h1);
        step();
        idle();
        step();
        drv(1, 0, 4'hF, 32'h10, 32'h0);
        chk("unmap_noalias", bus.readData, 32'hDEAD_BEEF);
        chk("mapped_err", {31'd0, bus.err}, 32'h0);
        drv(1, 0, 4'hF, 32'h0000_1000, 32'h0);
        chk("ram_end_err", {31'd0, bus.err}, 32'h1);
        drv(1, 0, 4'hF, 32'h0000_0FFC, 32'h0);
        chk("ram_last_err", {31'd0, bus.err}, 32'h0);

        // Reset discards a pending store
        step();
        drv(1, 1, 4'hF, 32'h30, 32'h5566_7788);
        step();
        idle();
        step();
        drv(1, 1, 4'hF, 32'h30, 32'h0000_00AA);
        step();
        idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        drv(1, 0, 4'hF, 32'h30, 32'h0);
        chk("rst_discard", bus.readData, 32'h5566_7788);

        // Timer: fresh reset released mid-cycle, so mtime=0 before the next edge
        step();
        idle();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        drv(1, 1, 4'hF, TB + 32'd4, 32'd5);
`ifdef DATA_MEM_RESP_TIMER_EN
        chk("tmr_wr_err", {31'd0, bus.err}, 32'h0);
        step();
        drv(1, 0, 4'hF, TB + 32'd4, 32'h0);
        chk("tmr_cmp_rd", bus.readData, 32'd5);
        drv(1, 0, 4'hF, TB, 32'h0);
        chk("tmr_mtime_rd", bus.readData, 32'd1);
        idle();
        for (int i = 2; i <= 5; i++) step();
        chk("tmr_irq_pre", {31'd0, irq}, 32'h0);
        step();
        chk("tmr_irq_set", {31'd0, irq}, 32'h1);
        drv(1, 0, 4'hF, TB + 32'd8, 32'h0);
        chk("tmr_status_rd", bus.readData, 32'h1);
        drv(1, 1, 4'h1, TB + 32'd8, 32'h1);
        step();
        idle();
        chk("tmr_irq_clr", {31'd0, irq}, 32'h0);
`else
        chk("tmr_wr_err", {31'd0, bus.err}, 32'h1);
        step();
        drv(1, 0, 4'hF, TB + 32'd4, 32'h0);
        chk("tmr_rd_err", {31'd0, bus.err}, 32'h1);
        chk("tmr_rd_rdata", bus.readData, 32'h0);
        drv(1, 0, 4'hF, TB + 32'd8, 32'h0);
        chk("tmr_st_err", {31'd0, bus.err}, 32'h1);
        idle();
        for (int i = 2; i <= 7; i++) begin
            step();
            chk("tmr_irq_tied", {31'd0, irq}, 32'h0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
